execute_cycle: RTL and testbench

EXECUTE_CYCLE -- requirements
Module: execute_cycle

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/alu.sv | 39 +++
 rtl/execute_cycle.sv | 202 ++++++++++++++++++++
 tb/tb_execute_cycle.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, forwarding selects,
// default widths and multiplier sizing.
// Imported by alu and execute_cycle.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF   = 9;

  // The shift-add multiplier always runs a fixed number of iterations.
  localparam int MUL_ITERS = 32;
  localparam int MUL_CNT_W = $clog2(MUL_ITERS);

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLT = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_MUL = 4'b1000
  } alu_op_t;

  // Operand forwarding selects. 2'b11 falls back to the register value.
  localparam logic [1:0] FWD_REG      = 2'b00;
  localparam logic [1:0] FWD_RESULT_W = 2'b01;
  localparam logic [1:0] FWD_ALU_M    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } ex_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage; zero flag always reflects src_a - src_b.
// Latency: 0 (pure combinational). Backpressure: none.
// Ports: op (4-bit opcode), src_a/src_b (operands), result, zero.
// MUL is not computed here; opcode 1000 yields 0 (the multiply lives in execute_cycle).
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic [DATA_W-1:0] diff;
  logic              slt;

  assign diff = src_a - src_b;
  assign zero = (diff == '0);
  assign slt  = ($signed(src_a) < $signed(src_b));

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = diff;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_XOR: result = src_a ^ src_b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, slt};
      ALU_SLL: result = src_a << src_b[4:0];
      ALU_SRL: result = src_a >> src_b[4:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: forwarding muxes, ALU, branch resolution, optional multi-cycle
// multiplier and the EX/MEM pipeline register.
// Latency: 1 edge for ALU ops; MUL (with MUL_EN) lands in M 34 edges after presentation.
// Backpressure: BusyE asks upstream to hold all E inputs; EX/MEM loads bubbles meanwhile.
// Ports: clk/rst (sync active-low); *E decode controls and operands; ForwardA_E/B_E,
// ResultW for forwarding; PCSrcE/PCTargetE branch outputs; *M registered EX/MEM outputs.
// Build option: define MUL_EN to compile in the 32-iteration shift-add multiplier.
module execute_cycle
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic [3:0]        ALUControlE,
  input  logic              ValidE,
  input  logic              FlushE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [4:0]        RD_E,
  input  logic [PC_W-1:0]   PCE,
  input  logic [PC_W-1:0]   PCPlus4E,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [DATA_W-1:0] ResultW,
  output logic              PCSrcE,
  output logic [PC_W-1:0]   PCTargetE,
  output logic              BusyE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [4:0]        RD_M,
  output logic [PC_W-1:0]   PCPlus4M,
  output logic [DATA_W-1:0] ALU_ResultM,
  output logic [DATA_W-1:0] WriteDataM
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              load_en;      // 1: capture a real instruction, 0: bubble
  logic [DATA_W-1:0] load_result;

  // Operand forwarding; 2'b11 behaves like the register path.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      FWD_RESULT_W: src_a = ResultW;
      FWD_ALU_M:    src_a = ALU_ResultM;
      default:      src_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    case (ForwardB_E)
      FWD_RESULT_W: fwd_b = ResultW;
      FWD_ALU_M:    fwd_b = ALU_ResultM;
      default:      fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  alu #(.DATA_W(DATA_W)) u_alu (
    .op     (ALUControlE),
    .src_a  (src_a),
    .src_b  (src_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign PCTargetE = PCE + Imm_Ext_E[PC_W-1:0];
  assign PCSrcE    = BranchE & alu_zero & ValidE & ~FlushE & ~BusyE;

`ifdef MUL_EN
  ex_state_t              state_q;
  ex_state_t              state_d;
  logic [MUL_CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]      mcand_q;
  logic [DATA_W-1:0]      mplier_q;
  logic [DATA_W-1:0]      acc_q;
  logic                   start_mul;
  logic                   busy_raw;

  assign start_mul = ValidE & ~FlushE & (ALUControlE == ALU_MUL);

  always_comb begin
    state_d     = state_q;
    busy_raw    = 1'b0;
    load_en     = 1'b0;
    load_result = alu_result;
    case (state_q)
      ST_IDLE: begin
        if (start_mul) begin
          busy_raw = 1'b1;
          state_d  = ST_MUL;
        end else begin
          load_en = ValidE & ~FlushE;
        end
      end
      ST_MUL: begin
        busy_raw = 1'b1;
        if (FlushE) begin
          state_d = ST_IDLE;
        end else if (cnt_q == MUL_CNT_W'(MUL_ITERS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Upstream still holds the MUL's E inputs here, so its controls are current.
        state_d     = ST_IDLE;
        load_en     = ValidE & ~FlushE;
        load_result = acc_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gated by rst so BusyE reads 0 for as long as reset is held.
  assign BusyE = rst & busy_raw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start_mul) begin
            mcand_q  <= src_a;
            mplier_q <= src_b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        ST_MUL: begin
          if (FlushE) begin
            cnt_q <= '0;
          end else begin
            // Only the low DATA_W product bits are kept, so everything wraps at DATA_W.
            if (mplier_q[0]) begin
              acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign BusyE       = 1'b0;
  assign load_en     = ValidE & ~FlushE;
  assign load_result = alu_result;
`endif

  // EX/MEM register; bubbles clear every field.
  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
    end else if (load_en) begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      ALU_ResultM <= load_result;
      WriteDataM  <= fwd_b;
    end else begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: ALU ops, forwarding, branch, flush/bubble,
// reset and, when MUL_EN is defined, the multi-cycle multiplier.
module tb_execute_cycle;
  import cpu_pkg::*;

  localparam int DW = 32;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
  logic [3:0]    ALUControlE;
  logic          ValidE, FlushE;
  logic [DW-1:0] RD1_E, RD2_E, Imm_Ext_E, ResultW;
  logic [4:0]    RD_E;
  logic [PW-1:0] PCE, PCPlus4E;
  logic [1:0]    ForwardA_E, ForwardB_E;
  logic          PCSrcE, BusyE, RegWriteM, MemWriteM, ResultSrcM;
  logic [PW-1:0] PCTargetE, PCPlus4M;
  logic [4:0]    RD_M;
  logic [DW-1:0] ALU_ResultM, WriteDataM;

  int n_cmp = 0;
  int n_err = 0;

  execute_cycle #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .ValidE(ValidE), .FlushE(FlushE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0; BranchE = 1'b0;
    ALUSrcE = 1'b0; ALUControlE = 4'b0000; ValidE = 1'b0; FlushE = 1'b0;
    RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0; ResultW = '0; RD_E = '0;
    PCE = '0; PCPlus4E = '0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    idle_inputs;
    ValidE = 1'b1; RegWriteE = 1'b1; ALUControlE = op; RD1_E = a; RD2_E = b;
  endtask

`ifdef MUL_EN
  task automatic run_mul(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] exp_p);
    int  busy_cycles;
    int  edges;
    bit  seen;
    idle_inputs;
    ValidE = 1'b1; RegWriteE = 1'b1; ALUControlE = 4'b1000;
    RD1_E = a; RD2_E = b; RD_E = 5'd7; PCPlus4E = 9'h044;
    #1;
    busy_cycles = 0; edges = 0; seen = 1'b0;
    while (!seen && edges < 60) begin
      if (BusyE) busy_cycles++;
      tick;
      edges++;
      if (RegWriteM) seen = 1'b1;
    end
    idle_inputs;
    chk({tag, "_edges"}, 64'(edges), 64'd34);
    chk({tag, "_busy"}, 64'(busy_cycles), 64'd33);
    chk({tag, "_res"}, 64'(ALU_ResultM), 64'(exp_p));
    chk({tag, "_rd"}, 64'(RD_M), 64'd7);
  endtask
`endif

  initial begin
    logic [3:0]    ops [9];
    logic [DW-1:0] as  [9];
    logic [DW-1:0] bs  [9];
    logic [DW-1:0] exs [9];

    ops = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0101, 4'b0110, 4'b0111, 4'b0000, 4'b0001};
    as  = '{32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0001,
            32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0003};
    bs  = '{32'hFF00_FF00, 32'h0000_00F1, 32'h0F0F_0F0F, 32'h0000_0001, 32'hFFFF_FFFF,
            32'h0000_0023, 32'h0000_001F, 32'h0000_0002, 32'h0000_0005};
    exs = '{32'hF000_F000, 32'h0F0F_00F1, 32'hF0F0_0F0F, 32'h0000_0001, 32'h0000_0000,
            32'h0000_0008, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFE};

    // Reset state
    idle_inputs;
    rst = 1'b0;
    tick; tick;
    chk("rst_regw", 64'(RegWriteM), 64'd0);
    chk("rst_res", 64'(ALU_ResultM), 64'd0);
    chk("rst_busy", 64'(BusyE), 64'd0);
    chk("rst_pc4", 64'(PCPlus4M), 64'd0);
    rst = 1'b1;

    // ADD 5 + 7
    alu_op(4'b0000, 32'd5, 32'd7);
    RD_E = 5'd3; PCPlus4E = 9'h008;
    tick;
    chk("add_res", 64'(ALU_ResultM), 64'd12);
    chk("add_regw", 64'(RegWriteM), 64'd1);
    chk("add_rd", 64'(RD_M), 64'd3);
    chk("add_pc4", 64'(PCPlus4M), 64'h008);
    chk("add_wd", 64'(WriteDataM), 64'd7);

    // Build ALU_ResultM = 20, then SUB with A forwarded from M and a taken branch
    alu_op(4'b0000, 32'd13, 32'd7);
    tick;
    chk("add20_res", 64'(ALU_ResultM), 64'd20);
    alu_op(4'b0001, 32'd999, 32'd20);
    RegWriteE = 1'b0; ForwardA_E = 2'b10; BranchE = 1'b1;
    PCE = 9'h1F8; Imm_Ext_E = 32'h0000_0010;
    #1;
    chk("br_taken", 64'(PCSrcE), 64'd1);
    chk("br_target", 64'(PCTargetE), 64'h008);
    tick;
    chk("sub_res", 64'(ALU_ResultM), 64'd0);
    chk("sub_regw", 64'(RegWriteM), 64'd0);

    // Branch not taken: ResultW forwarded (5) vs register 4
    alu_op(4'b0001, 32'd0, 32'd4);
    ForwardA_E = 2'b01; ResultW = 32'd5; BranchE = 1'b1;
    #1;
    chk("br_nt", 64'(PCSrcE), 64'd0);
    // Immediate operand equal to forwarded A makes Zero true
    ALUSrcE = 1'b1; Imm_Ext_E = 32'd5; PCE = 9'h010;
    #1;
    chk("br_imm", 64'(PCSrcE), 64'd1);
    chk("br_imm_tgt", 64'(PCTargetE), 64'h015);

    // ForwardB from ResultW feeds both SrcB and WriteData; ForwardA=11 uses register
    alu_op(4'b0000, 32'd1, 32'd77);
    ForwardA_E = 2'b11; ForwardB_E = 2'b01; ResultW = 32'h100;
    tick;
    chk("fwdb_res", 64'(ALU_ResultM), 64'h101);
    chk("fwdb_wd", 64'(WriteDataM), 64'h100);

    // Flush squashes a store and blocks the branch
    alu_op(4'b0001, 32'd9, 32'd9);
    MemWriteE = 1'b1; FlushE = 1'b1; BranchE = 1'b1;
    #1;
    chk("flush_br", 64'(PCSrcE), 64'd0);
    tick;
    chk("flush_memw", 64'(MemWriteM), 64'd0);
    chk("flush_regw", 64'(RegWriteM), 64'd0);

    // Invalid slot loads a bubble
    alu_op(4'b0000, 32'd1, 32'd1);
    ValidE = 1'b0; BranchE = 1'b1;
    #1;
    chk("inv_br", 64'(PCSrcE), 64'd0);
    tick;
    chk("inv_regw", 64'(RegWriteM), 64'd0);

    // ALU operation table
    for (int i = 0; i < 9; i++) begin
      alu_op(ops[i], as[i], bs[i]);
      tick;
      chk($sformatf("alu_tbl%0d", i), 64'(ALU_ResultM), 64'(exs[i]));
    end

`ifdef MUL_EN
    run_mul("mul1", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
    run_mul("mul2", 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD);

    // Reset in the middle of a multiply
    alu_op(4'b1000, 32'd6, 32'd7);
    #1;
    chk("mulrst_busy0", 64'(BusyE), 64'd1);
    for (int i = 0; i < 10; i++) tick;
    rst = 1'b0;
    tick;
    chk("mulrst_busy", 64'(BusyE), 64'd0);
    chk("mulrst_regw", 64'(RegWriteM), 64'd0);
    chk("mulrst_memw", 64'(MemWriteM), 64'd0);
    chk("mulrst_res", 64'(ALU_ResultM), 64'd0);
    chk("mulrst_rd", 64'(RD_M), 64'd0);
    rst = 1'b1;
    alu_op(4'b0000, 32'd2, 32'd3);
    #1;
    chk("mulrst_add_busy", 64'(BusyE), 64'd0);
    tick;
    chk("mulrst_add_res", 64'(ALU_ResultM), 64'd5);
    chk("mulrst_add_regw", 64'(RegWriteM), 64'd1);

    // Flush aborts a running multiply
    alu_op(4'b1000, 32'd6, 32'd7);
    for (int i = 0; i < 5; i++) tick;
    FlushE = 1'b1;
    tick;
    chk("mulfl_regw", 64'(RegWriteM), 64'd0);
    chk("mulfl_busy", 64'(BusyE), 64'd0);
    alu_op(4'b0000, 32'd4, 32'd4);
    tick;
    chk("mulfl_add", 64'(ALU_ResultM), 64'd8);

    // Flush presented together with a MUL: nothing starts
    alu_op(4'b1000, 32'd6, 32'd7);
    FlushE = 1'b1;
    #1;
    chk("mulsim_busy", 64'(BusyE), 64'd0);
    tick;
    chk("mulsim_regw", 64'(RegWriteM), 64'd0);
    alu_op(4'b0000, 32'd10, 32'd1);
    #1;
    chk("mulsim_add_busy", 64'(BusyE), 64'd0);
    tick;
    chk("mulsim_add", 64'(ALU_ResultM), 64'd11);
`else
    // Without the multiplier, opcode 1000 is a single-cycle op producing 0
    alu_op(4'b0000, 32'd3, 32'd4);
    tick;
    alu_op(4'b1000, 32'd6, 32'd7);
    #1;
    chk("nomul_busy", 64'(BusyE), 64'd0);
    tick;
    chk("nomul_res", 64'(ALU_ResultM), 64'd0);
    chk("nomul_regw", 64'(RegWriteM), 64'd1);
`endif

    idle_inputs;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
